// File: rtl/lfsr_tsched_pkg.sv
// Shared definitions for the LFSR timer scheduler: FSM state encoding and
// sizing constants used by the top level and the per-channel counters.
package lfsr_tsched_pkg;

   // Scheduler states: timebase stopped, timebase restarting, timebase running.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2
   } tsched_state_e;

   // Largest supported channel count.
   localparam int N_CH_MAX  = 8;

   // Default width of each duration counter, in 1 ms ticks.
   localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/tsched_channel.sv
// One countdown channel of the timer scheduler. It loads a duration on start,
// counts down on each qualified 1 ms tick and pulses done for one cycle when
// the count runs out. Start has priority over cancel, and cancel has priority
// over a tick. A start with a zero duration expires at once: it pulses done
// and leaves the channel idle, even when it lands on a running count.
module tsched_channel
   import lfsr_tsched_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] dur,
   input  logic             cancel,
   input  logic             tick_qual,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Next-state logic: load/restart, cancel, then tick-driven countdown.
   always_comb begin
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (start) begin
         if (dur != CNT_ZERO) begin
            cnt_d  = dur;
            busy_d = 1'b1;
         end else begin
            cnt_d  = CNT_ZERO;
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end else if (cancel) begin
         cnt_d  = CNT_ZERO;
         busy_d = 1'b0;
      end else if (tick_qual && busy_q) begin
         if (cnt_q == CNT_ONE) begin
            cnt_d  = CNT_ZERO;
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Channel state registers; reset aborts the count without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= CNT_ZERO;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: rtl/lfsr_timer_scheduler.sv
// Shares one 1 ms LFSR timebase among N_CH countdown channels. The scheduler
// keeps the timebase stopped while no channel is counting. The first accepted
// start restarts the timebase with a one-cycle tb_clear, so that channel
// expires exactly D ticks later. Ticks seen outside RUN are stale and dropped.
// N_CH may range from 1 to N_CH_MAX.
// Optional build macro LFSR_TSCHED_STATUS_EN adds err_clr / restart_err, a
// sticky per-channel flag that records a start issued to a busy channel.
module lfsr_timer_scheduler
   import lfsr_tsched_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef LFSR_TSCHED_STATUS_EN
   input  logic                  err_clr,
   output logic [N_CH-1:0]       restart_err,
`endif
   input  logic [N_CH-1:0]       start,
   input  logic [N_CH*CNT_W-1:0] dur,
   input  logic [N_CH-1:0]       cancel,
   input  logic                  tick_in,
   output logic                  tick_en,
   output logic                  tb_clear,
   output logic [N_CH-1:0]       busy,
   output logic [N_CH-1:0]       done,
   output logic                  idle
);

   tsched_state_e   state_q;
   logic            tick_en_q;
   logic            tb_clear_q;
   logic            idle_q;
   logic [N_CH-1:0] accept_s;
   logic [N_CH-1:0] busy_s;
   logic            tick_qual_s;

   // Only ticks that arrive while the timebase is running count down.
   assign tick_qual_s = tick_in && (state_q == ST_RUN);

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      // A start with a non-zero duration is what keeps the timebase alive.
      assign accept_s[gi] = start[gi] && (dur[gi*CNT_W +: CNT_W] != {CNT_W{1'b0}});

      tsched_channel #(
         .CNT_W     (CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .start     (start[gi]),
         .dur       (dur[gi*CNT_W +: CNT_W]),
         .cancel    (cancel[gi]),
         .tick_qual (tick_qual_s),
         .busy      (busy_s[gi]),
         .done      (done[gi])
      );
   end

   // Scheduler FSM; the timebase controls are registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tick_en_q  <= 1'b0;
         tb_clear_q <= 1'b0;
         idle_q     <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|accept_s) begin
                  state_q    <= ST_CLEAR;
                  tick_en_q  <= 1'b0;
                  tb_clear_q <= 1'b1;
                  idle_q     <= 1'b0;
               end else begin
                  state_q    <= ST_IDLE;
                  tick_en_q  <= 1'b0;
                  tb_clear_q <= 1'b0;
                  idle_q     <= 1'b1;
               end
            end
            ST_CLEAR: begin
               state_q    <= ST_RUN;
               tick_en_q  <= 1'b1;
               tb_clear_q <= 1'b0;
               idle_q     <= 1'b0;
            end
            ST_RUN: begin
               if (!(|busy_s) && !(|accept_s)) begin
                  state_q    <= ST_IDLE;
                  tick_en_q  <= 1'b0;
                  tb_clear_q <= 1'b0;
                  idle_q     <= 1'b1;
               end else begin
                  state_q    <= ST_RUN;
                  tick_en_q  <= 1'b1;
                  tb_clear_q <= 1'b0;
                  idle_q     <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               tick_en_q  <= 1'b0;
               tb_clear_q <= 1'b0;
               idle_q     <= 1'b1;
            end
         endcase
      end
   end

`ifdef LFSR_TSCHED_STATUS_EN
   logic [N_CH-1:0] restart_err_q;

   // Sticky restart flags; a new hit in the clearing cycle survives the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         restart_err_q <= {N_CH{1'b0}};
      end else begin
         restart_err_q <= (restart_err_q & ~{N_CH{err_clr}}) | (start & busy_s);
      end
   end

   assign restart_err = restart_err_q;
`endif

   assign tick_en  = tick_en_q;
   assign tb_clear = tb_clear_q;
   assign idle     = idle_q;
   assign busy     = busy_s;

endmodule

// File: tb/tb_lfsr_timer_scheduler.sv
// Self-checking bench for lfsr_timer_scheduler: directed scenarios with
// hand-computed expectations, then randomized traffic, all compared each cycle
// against a behavioural model (remaining-ms counts per channel plus a mode).
module tb_lfsr_timer_scheduler;

   localparam int N = 4;
   localparam int W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     start;
   logic [N*W-1:0]   dur;
   logic [N-1:0]     cancel;
   logic             tick_in;
   logic             tick_en;
   logic             tb_clear;
   logic [N-1:0]     busy;
   logic [N-1:0]     done;
   logic             idle;
`ifdef LFSR_TSCHED_STATUS_EN
   logic             err_clr;
   logic [N-1:0]     restart_err;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int clears_seen = 0;

   // Behavioural model: remaining ms per channel and timebase mode
   // (0 = stopped, 1 = restarting, 2 = running).
   int       rem [N];
   bit [N-1:0] m_busy;
   bit [N-1:0] m_done;
   bit [N-1:0] m_err;
   int       mode;

   always #5 clk = ~clk;

   lfsr_timer_scheduler #(.N_CH(N), .CNT_W(W)) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef LFSR_TSCHED_STATUS_EN
      .err_clr     (err_clr),
      .restart_err (restart_err),
`endif
      .start       (start),
      .dur         (dur),
      .cancel      (cancel),
      .tick_in     (tick_in),
      .tick_en     (tick_en),
      .tb_clear    (tb_clear),
      .busy        (busy),
      .done        (done),
      .idle        (idle)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N*W-1:0] dv(input int ch, input int val);
      logic [N*W-1:0] v;
      v = '0;
      v[ch*W +: W] = val[W-1:0];
      return v;
   endfunction

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      bit was_busy;
      bit took;
      bit running;
      int d;
      if (rst) begin
         for (int i = 0; i < N; i++) rem[i] = 0;
         m_busy = '0; m_done = '0; m_err = '0; mode = 0;
         return;
      end
      was_busy = (m_busy != 0);
      running  = (mode == 2);
      took     = 0;
      m_done   = '0;
`ifdef LFSR_TSCHED_STATUS_EN
      if (err_clr) m_err = '0;
      m_err = m_err | (start & m_busy);
`endif
      for (int i = 0; i < N; i++) begin
         d = int'(dur[i*W +: W]);
         if (start[i]) begin
            if (d > 0) begin rem[i] = d; m_busy[i] = 1; took = 1; end
            else begin rem[i] = 0; m_busy[i] = 0; m_done[i] = 1; end
         end else if (cancel[i]) begin
            rem[i] = 0; m_busy[i] = 0;
         end else if (tick_in && running && m_busy[i]) begin
            rem[i] = rem[i] - 1;
            if (rem[i] == 0) begin m_busy[i] = 0; m_done[i] = 1; end
         end
      end
      if (mode == 0) mode = took ? 1 : 0;
      else if (mode == 1) mode = 2;
      else if (!was_busy && !took) mode = 0;
   endtask

   task automatic compare_all();
      check("tick_en",  tick_en,  (mode == 2));
      check("tb_clear", tb_clear, (mode == 1));
      check("idle",     idle,     (mode == 0));
      check("busy",     busy,     m_busy);
      check("done",     done,     m_done);
`ifdef LFSR_TSCHED_STATUS_EN
      check("restart_err", restart_err, m_err);
`endif
   endtask

   // Apply one cycle of stimulus, step the model, then compare after the edge.
   task automatic cyc(input logic [N-1:0] s, input logic [N*W-1:0] d,
                      input logic [N-1:0] c, input logic t);
      start = s; dur = d; cancel = c; tick_in = t;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      if (tb_clear === 1'b1) clears_seen++;
      start = '0; dur = '0; cancel = '0; tick_in = 1'b0;
   endtask

   task automatic idle_cyc(input int n);
      for (int k = 0; k < n; k++) cyc('0, '0, '0, 1'b0);
   endtask

   task automatic tick_cyc(input int n);
      for (int k = 0; k < n; k++) cyc('0, '0, '0, 1'b1);
   endtask

   initial begin
      rst = 1'b1; start = '0; dur = '0; cancel = '0; tick_in = 1'b0;
`ifdef LFSR_TSCHED_STATUS_EN
      err_clr = 1'b0;
`endif
      idle_cyc(2);
      check("rst_idle", idle, 1'b1);
      check("rst_tick_en", tick_en, 1'b0);
      rst = 1'b0;
      idle_cyc(2);

      // 1: single channel from IDLE, exact D ticks after the clear.
      cyc(4'b0001, dv(0, 3), '0, 1'b0);
      check("t1_tb_clear", tb_clear, 1'b1);
      check("t1_tick_en_clr", tick_en, 1'b0);
      idle_cyc(1);
      check("t1_tick_en", tick_en, 1'b1);
      tick_cyc(2);
      check("t1_no_early_done", done, 4'b0000);
      tick_cyc(1);
      check("t1_done", done, 4'b0001);
      check("t1_busy", busy, 4'b0000);
      idle_cyc(1);
      check("t1_idle", idle, 1'b1);
      idle_cyc(2);

      // 2: second channel joins a running timebase; one clear in total.
      clears_seen = 0;
      cyc(4'b0001, dv(0, 5), '0, 1'b0);
      idle_cyc(1);
      tick_cyc(2);
      cyc(4'b0010, dv(1, 2), '0, 1'b0);
      tick_cyc(1);
      tick_cyc(1);
      check("t2_done1", done, 4'b0010);
      tick_cyc(1);
      check("t2_done0", done, 4'b0001);
      idle_cyc(2);
      check("t2_one_clear", clears_seen, 1);

      // 3: zero duration pulses done immediately and leaves the FSM idle.
      cyc(4'b0100, dv(2, 0), '0, 1'b0);
      check("t3_done", done, 4'b0100);
      check("t3_busy", busy, 4'b0000);
      check("t3_tick_en", tick_en, 1'b0);
      idle_cyc(1);
      check("t3_idle", idle, 1'b1);

      // 4: restart on the final tick wins over expiry.
      cyc(4'b0001, dv(0, 1), '0, 1'b0);
      idle_cyc(1);
      cyc(4'b0001, dv(0, 4), '0, 1'b1);
      check("t4_no_done", done, 4'b0000);
      check("t4_busy", busy, 4'b0001);
`ifdef LFSR_TSCHED_STATUS_EN
      check("t4_err_set", restart_err, 4'b0001);
      err_clr = 1'b1;
      idle_cyc(1);
      err_clr = 1'b0;
      check("t4_err_clr", restart_err, 4'b0000);
`endif
      tick_cyc(3);
      check("t4_still_busy", busy, 4'b0001);
      tick_cyc(1);
      check("t4_done", done, 4'b0001);
      idle_cyc(2);

      // 5: cancel the only busy channel.
      cyc(4'b0010, dv(1, 6), '0, 1'b0);
      idle_cyc(1);
      tick_cyc(2);
      cyc('0, '0, 4'b0010, 1'b0);
      check("t5_busy", busy, 4'b0000);
      check("t5_no_done", done, 4'b0000);
      idle_cyc(1);
      check("t5_tick_en", tick_en, 1'b0);
      check("t5_idle", idle, 1'b1);

      // 6: reset mid-count aborts everything.
      cyc(4'b1001, dv(0, 2) | dv(3, 2), '0, 1'b0);
      idle_cyc(1);
      tick_cyc(1);
      rst = 1'b1;
      idle_cyc(1);
      rst = 1'b0;
      check("t6_busy", busy, 4'b0000);
      check("t6_idle", idle, 1'b1);
      tick_cyc(3);
      check("t6_no_done", done, 4'b0000);

      // Randomized traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         logic [N-1:0]   s, c;
         logic [N*W-1:0] d;
         s = '0; c = '0; d = '0;
         for (int i = 0; i < N; i++) begin
            s[i] = ($urandom_range(0, 11) == 0);
            c[i] = ($urandom_range(0, 23) == 0);
            d[i*W +: W] = W'($urandom_range(0, 10));
         end
         rst = ($urandom_range(0, 299) == 0);
`ifdef LFSR_TSCHED_STATUS_EN
         err_clr = ($urandom_range(0, 15) == 0);
`endif
         cyc(s, d, c, ($urandom_range(0, 2) == 0));
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
